// File: rtl/fp_wire.sv
// Shared types for the fp_mac datapath and its requester arbiter.
package fp_wire;
  localparam int FP_MAC_A_W   = 56;
  localparam int FP_MAC_D_W   = 110;
  localparam int FP_MAC_TAG_W = 3;  // wide enough for up to 8 requesters

  typedef struct packed {
    logic [FP_MAC_A_W-1:0] a;
    logic [FP_MAC_A_W-1:0] b;
    logic [FP_MAC_A_W-1:0] c;
    logic                  op;
  } fp_mac_in_type;

  typedef struct packed {
    logic [FP_MAC_D_W-1:0] d;
  } fp_mac_out_type;

  typedef struct packed {
    logic                    valid;
    logic [FP_MAC_TAG_W-1:0] tag;
    logic [FP_MAC_A_W-1:0]   a;
    logic [FP_MAC_A_W-1:0]   b;
    logic [FP_MAC_A_W-1:0]   c;
    logic                    op;
  } fp_mac_arb_s1_type;
endpackage

// File: rtl/fp_mac_rr.sv
// Rotate-priority picker: first requester at or above ptr, or only the lock owner.
module fp_mac_rr #(
  parameter  int NUM_REQ = 2,
  localparam int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  input  logic               lock,
  input  logic [TAG_W-1:0]   owner,
  output logic [NUM_REQ-1:0] grant,
  output logic [TAG_W-1:0]   idx,
  output logic               hit
);
  logic [TAG_W-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    j     = '0;
    if (lock) begin
      if (req[owner]) begin
        grant[owner] = 1'b1;
        idx          = owner;
        hit          = 1'b1;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = TAG_W'((int'(ptr) + k) % NUM_REQ);
        if (!hit && req[j]) begin
          grant[j] = 1'b1;
          idx      = j;
          hit      = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/fp_mac_arb.sv
// Shares one combinational fp_mac among NUM_REQ requesters: issue register,
// result register, round-robin grant with optional locking.
module fp_mac_arb
  import fp_wire::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ-1:0]           req_op,
  input  logic [NUM_REQ*FP_MAC_A_W-1:0] req_a,
  input  logic [NUM_REQ*FP_MAC_A_W-1:0] req_b,
  input  logic [NUM_REQ*FP_MAC_A_W-1:0] req_c,
  output fp_mac_in_type                mac_i,
  input  fp_mac_out_type               mac_o,
  output logic [NUM_REQ-1:0]           resp_valid,
  input  logic [NUM_REQ-1:0]           resp_ready,
  output logic [FP_MAC_D_W-1:0]        resp_d,
  output logic                         busy
);
  fp_mac_arb_s1_type     s1;
  logic                  s2_valid;
  logic [TAG_W-1:0]      s2_tag;
  logic [FP_MAC_D_W-1:0] s2_d;
  logic [TAG_W-1:0]      rr_ptr, lock_owner, gidx;
  logic                  locked, hit;
  logic [NUM_REQ-1:0]    grant;
  logic                  s2_load, s1_load, hs;

  fp_mac_rr #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .lock  (locked),
    .owner (lock_owner),
    .grant (grant),
    .idx   (gidx),
    .hit   (hit)
  );

  assign s2_load = !s2_valid | resp_ready[s2_tag];
  assign s1_load = !s1.valid | s2_load;
  // reset gating keeps req_ready low while reset is held
  assign hs        = hit & s1_load & !flush & reset;
  assign req_ready = hs ? grant : '0;
  assign resp_d    = s2_d;
  assign busy      = s1.valid | s2_valid;

  always_comb begin
    resp_valid = '0;
    if (s2_valid) resp_valid[s2_tag] = 1'b1;
  end

  always_comb begin
    mac_i = '0;
    if (s1.valid) begin
      mac_i.a  = s1.a;
      mac_i.b  = s1.b;
      mac_i.c  = s1.c;
      mac_i.op = s1.op;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1         <= '0;
      s2_valid   <= 1'b0;
      s2_tag     <= '0;
      s2_d       <= '0;
      rr_ptr     <= '0;
      locked     <= 1'b0;
      lock_owner <= '0;
    end else if (flush) begin
      s1.valid <= 1'b0;
      s2_valid <= 1'b0;
      locked   <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= s1.valid;
        if (s1.valid) begin
          s2_d   <= mac_o.d;
          s2_tag <= s1.tag[TAG_W-1:0];
        end
      end
      if (s1_load) s1.valid <= hs;
      if (hs) begin
        s1.tag     <= FP_MAC_TAG_W'(gidx);
        s1.a       <= req_a[gidx*FP_MAC_A_W +: FP_MAC_A_W];
        s1.b       <= req_b[gidx*FP_MAC_A_W +: FP_MAC_A_W];
        s1.c       <= req_c[gidx*FP_MAC_A_W +: FP_MAC_A_W];
        s1.op      <= req_op[gidx];
        rr_ptr     <= (gidx == TAG_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
        locked     <= req_lock[gidx];
        lock_owner <= gidx;
      end
    end
  end
endmodule

// File: tb/tb_fp_mac_arb.sv
// Directed bench for fp_mac_arb with a behavioural fp_mac hooked to mac_i/mac_o.
module tb_fp_mac_arb;
  import fp_wire::*;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   req_valid = '0, req_ready, req_lock = '0, req_op = '0;
  logic [111:0] req_a = '0, req_b = '0, req_c = '0;
  fp_mac_in_type  mac_i;
  fp_mac_out_type mac_o;
  logic [1:0]   resp_valid, resp_ready = 2'b11;
  logic [109:0] resp_d;
  logic         busy;
  int           nvec = 0, nerr = 0;

  localparam logic [109:0] P54 = 110'd1 << 54;

  fp_mac_arb #(.NUM_REQ(2)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .mac_i(mac_i), .mac_o(mac_o),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_d(resp_d), .busy(busy)
  );

  always #5 clock = ~clock;

  // external fp_mac: d = {a,54'h0} +/- b*c, truncated to 110 bits
  logic signed [111:0] prod;
  always_comb begin
    prod    = $signed(mac_i.b) * $signed(mac_i.c);
    mac_o.d = mac_i.op ? ({mac_i.a, 54'h0} - prod[109:0]) : ({mac_i.a, 54'h0} + prod[109:0]);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_r(input int i, input logic [55:0] a, b, c, input logic op, lock);
    req_a[i*56 +: 56] = a;
    req_b[i*56 +: 56] = b;
    req_c[i*56 +: 56] = c;
    req_op[i]   = op;
    req_lock[i] = lock;
  endtask

  task automatic do_reset();
    req_valid = '0; flush = 1'b0; resp_ready = 2'b11; req_lock = '0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 2'b11;
    set_r(0, 56'd7, 56'd1, 56'd1, 1'b0, 1'b0);
    #3;
    nvec++; if (req_ready !== 2'b00) begin nerr++; $display("FAIL reset_ready got %b want 00", req_ready); end
    nvec++; if (resp_valid !== 2'b00) begin nerr++; $display("FAIL reset_rv got %b want 00", resp_valid); end
    nvec++; if (resp_d !== '0 || mac_i !== '0) begin nerr++; $display("FAIL reset_data got d=%h mac_i=%h want 0", resp_d, mac_i); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    req_valid = '0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_op();
    logic [55:0]  bt [3] = '{56'd3, 56'd3, 56'hFFFFFFFFFFFFFE};
    logic         ot [3] = '{1'b0, 1'b1, 1'b0};
    logic [109:0] et [3] = '{P54 + 110'd15, P54 - 110'd15, P54 - 110'd6};
    fp_mac_in_type mexp;
    for (int v = 0; v < 3; v++) begin
      set_r(0, 56'd1, bt[v], (v == 2) ? 56'd3 : 56'd5, ot[v], 1'b0);
      req_valid = 2'b01;
      #1;
      nvec++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL single_ready[%0d] got %b want 01", v, req_ready); end
      tick();
      req_valid = 2'b00;
      #1;
      mexp = '{a: 56'd1, b: bt[v], c: (v == 2) ? 56'd3 : 56'd5, op: ot[v]};
      nvec++; if (mac_i !== mexp || busy !== 1'b1) begin nerr++; $display("FAIL single_mac_i[%0d] got %h busy=%b want %h busy=1", v, mac_i, busy, mexp); end
      tick();
      nvec++; if (resp_valid !== 2'b01 || resp_d !== et[v]) begin nerr++; $display("FAIL single_resp[%0d] got rv=%b d=%h want rv=01 d=%h", v, resp_valid, resp_d, et[v]); end
      tick();
      nvec++; if (busy !== 1'b0 || resp_valid !== 2'b00) begin nerr++; $display("FAIL single_idle[%0d] got busy=%b rv=%b want 0/00", v, busy, resp_valid); end
    end
  endtask

  task automatic test_fairness();
    int g;
    logic [109:0] exp_d;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        set_r(0, 56'(100 + (k + 1) / 2), 56'd0, 56'd0, 1'b0, 1'b0);
        set_r(1, 56'(110 + k / 2), 56'd0, 56'd0, 1'b0, 1'b0);
        req_valid = 2'b11;
      end else req_valid = 2'b00;
      #1;
      if (k < 6) begin
        nvec++; if (req_ready !== 2'(1 << (k % 2))) begin nerr++; $display("FAIL fair_grant[%0d] got %b want %b", k, req_ready, 2'(1 << (k % 2))); end
      end
      if (k >= 2) begin
        g = (k - 2) % 2;
        exp_d = {56'(100 + 10 * g + (k - 2) / 2), 54'h0};
        nvec++; if (resp_valid !== 2'(1 << g) || resp_d !== exp_d) begin nerr++; $display("FAIL fair_resp[%0d] got rv=%b d=%h want rv=%b d=%h", k, resp_valid, resp_d, 2'(1 << g), exp_d); end
      end
      tick();
    end
  endtask

  task automatic test_lock();
    logic [1:0] tv  [7] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
    logic       tl  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int         ta  [7] = '{21, 21, 22, 23, 23, 23, 23};
    logic [1:0] er  [7] = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
    logic [1:0] ev  [7] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b01};
    int         ea  [7] = '{0, 0, 21, 0, 22, 23, 5};
    do_reset();
    set_r(0, 56'd5, 56'd0, 56'd0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      set_r(1, 56'(ta[k]), 56'd0, 56'd0, 1'b0, tl[k]);
      req_valid = tv[k];
      #1;
      nvec++; if (req_ready !== er[k]) begin nerr++; $display("FAIL lock_ready[%0d] got %b want %b", k, req_ready, er[k]); end
      if (ev[k] != 2'b00) begin
        nvec++; if (resp_valid !== ev[k] || resp_d !== {56'(ea[k]), 54'h0}) begin nerr++; $display("FAIL lock_resp[%0d] got rv=%b d=%h want rv=%b a=%0d", k, resp_valid, resp_d, ev[k], ea[k]); end
      end else begin
        nvec++; if (resp_valid !== 2'b00) begin nerr++; $display("FAIL lock_rv[%0d] got %b want 00", k, resp_valid); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] trr [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
    logic       tv  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] er  [8] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [1:0] ev  [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    int         ea  [8] = '{0, 0, 30, 30, 30, 31, 32, 0};
    int n = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      resp_ready = trr[k];
      set_r(0, 56'(30 + n), 56'd0, 56'd0, 1'b0, 1'b0);
      req_valid = {1'b0, tv[k]};
      #1;
      nvec++; if (req_ready !== er[k]) begin nerr++; $display("FAIL bp_ready[%0d] got %b want %b", k, req_ready, er[k]); end
      if (ev[k] != 2'b00) begin
        nvec++; if (resp_valid !== ev[k] || resp_d !== {56'(ea[k]), 54'h0}) begin nerr++; $display("FAIL bp_resp[%0d] got rv=%b d=%h want rv=%b a=%0d", k, resp_valid, resp_d, ev[k], ea[k]); end
      end else if (k == 7) begin
        nvec++; if (busy !== 1'b0 || resp_valid !== 2'b00) begin nerr++; $display("FAIL bp_drain got busy=%b rv=%b want 0/00", busy, resp_valid); end
      end
      if (req_ready[0]) n++;
      tick();
    end
  endtask

  task automatic test_flush_reset();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      resp_ready = 2'b00;
      for (int k = 0; k < 2; k++) begin
        set_r(0, 56'(40 + k), 56'd0, 56'd0, 1'b0, 1'b0);
        req_valid = 2'b01;
        tick();
      end
      nvec++; if (busy !== 1'b1 || resp_valid !== 2'b01) begin nerr++; $display("FAIL fr_full[%0d] got busy=%b rv=%b want 1/01", pass, busy, resp_valid); end
      if (pass == 0) begin
        flush = 1'b1;
        #1;
        nvec++; if (req_ready !== 2'b00) begin nerr++; $display("FAIL flush_ready got %b want 00", req_ready); end
        tick();
        flush = 1'b0;
        req_valid = 2'b00;
        #1;
      end else begin
        reset = 1'b0;
        #1;
        nvec++; if (resp_d !== '0) begin nerr++; $display("FAIL rst_mid_d got %h want 0", resp_d); end
      end
      nvec++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin nerr++; $display("FAIL fr_empty[%0d] got rv=%b busy=%b want 00/0", pass, resp_valid, busy); end
      reset = 1'b1;
      resp_ready = 2'b11;
      set_r(0, 56'd1, 56'd3, 56'd5, 1'b0, 1'b0);
      req_valid = 2'b01;
      #1;
      nvec++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL fr_recover_ready[%0d] got %b want 01", pass, req_ready); end
      tick();
      req_valid = 2'b00;
      tick();
      nvec++; if (resp_valid !== 2'b01 || resp_d !== P54 + 110'd15) begin nerr++; $display("FAIL fr_recover_resp[%0d] got rv=%b d=%h want 01 d=%h", pass, resp_valid, resp_d, P54 + 110'd15); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_fairness();
    test_lock();
    test_backpressure();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fp_mac_arb.md
Name: fp_mac_arb

Overview:
- Round-robin arbiter and two-stage sequencer that shares one combinational fp_mac datapath among NUM_REQ requesters, e.g. the divide/sqrt iteration units and the fused multiply-add unit.
- Registers the winner's operands, drives the shared MAC from that register, and captures the 110-bit result with the owner's tag.
- Returns the result to the owner over a valid/ready response channel.
- Supports grant locking so an iterative requester can issue back-to-back operations without interleaving.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TAG_W, $clog2(NUM_REQ), localparam; width of the owner tag.

Ports:
- clock  in  1  single clock for all state.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops all in-flight operations.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept.
- req_lock  in  NUM_REQ  keep the grant on this requester after this operation.
- req_op  in  NUM_REQ  0: a+b*c, 1: a-b*c.
- req_a  in  NUM_REQ*56  addend, slice i = requester i.
- req_b  in  NUM_REQ*56  signed multiplicand.
- req_c  in  NUM_REQ*56  signed multiplier.
- mac_i  out  fp_mac_in_type  operands to the shared fp_mac (a, b, c, op).
- mac_o  in  fp_mac_out_type  result d[109:0] from the shared fp_mac.
- resp_valid  out  NUM_REQ  one-hot; result available for that requester.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_d  out  110  result, shared by all requesters.
- busy  out  1  high when either stage is occupied.

Behaviour:
- Reset (reset=0, asynchronous): s1_valid=0, s2_valid=0, rr_ptr=0, locked=0. All outputs read 0 (req_ready, resp_valid, resp_d, mac_i, busy).
- Grant selection (combinational):
  - If locked=1, only lock_owner is eligible.
  - Otherwise, the first requester with req_valid=1 searching from rr_ptr upward, wrapping modulo NUM_REQ.
- Handshake rules:
  - req_ready[i] = grant[i] & s1_load. req_ready may depend on req_valid; req_valid must not depend on req_ready.
  - A requester holds valid, operands, op and lock stable until ready is returned.
- Stage 1 (issue register): s1_load = !s1_valid | s2_load. On a handshake it loads a, b, c, op and tag. mac_i is driven only from s1 registers, and is 0 when s1_valid=0.
- Stage 2 (result register): s2_load = !s2_valid | (resp_ready[s2_tag] & resp_valid[s2_tag]). When s1_valid & s2_load, it captures mac_o.d and s1_tag.
- Response: resp_valid[s2_tag] = s2_valid. resp_d = s2_d, held stable while stalled. Backpressure propagates: s2 full and unaccepted freezes s1, so req_ready goes low.
- Latency: handshake in cycle N gives resp_valid in cycle N+2. Throughput is 1 op/cycle with resp_ready held high.
- Pointer update, on each handshake by winner g:
  - rr_ptr <= (g+1) mod NUM_REQ.
  - locked <= req_lock[g]; lock_owner <= g.
  - While locked, rr_ptr still advances but is ignored until the lock releases.
- Lock release: a handshake by lock_owner with req_lock=0. If lock_owner deasserts req_valid while locked, the lock is held and other requesters stall. flush also clears locked.
- flush:
  - Next edge: s1_valid=0, s2_valid=0, locked=0; rr_ptr unchanged.
  - req_ready forced 0 in the flush cycle; no handshake occurs.
  - A response being accepted in the same cycle counts as delivered.
- Simultaneous events: resp accept and new s2 load in the same cycle is legal (full throughput). Tie for grant is resolved by rr_ptr order.
- Arithmetic is owned by fp_mac: d = {a,54'h0} ± b*c truncated to 110 bits. The arbiter never modifies operands or results.
- busy = s1_valid | s2_valid.

Decomposition:
- fp_wire package:
  - existing fp_mac_in_type / fp_mac_out_type;
  - new constants FP_MAC_A_W=56, FP_MAC_D_W=110;
  - new typedef fp_mac_arb_s1_type (valid, tag, a, b, c, op).
- Sub-module fp_mac_rr: combinational rotate-priority picker (req, ptr, lock, owner -> one-hot grant, index).
- fp_mac itself stays outside and is connected by the parent.

Test Plan:
- Single op, r0: a=1, b=3, c=5, op=0 at cycle 0 -> resp_valid=01 at cycle 2, resp_d=2^54+15. With op=1 -> 2^54-15.
- Signed operand: b=-2 (56-bit two's complement), c=3, a=1, op=0 -> resp_d=2^54-6.
- Fairness: both requesters hold valid for 6 cycles with resp_ready=11 -> grants alternate r0, r1, r0, r1… and 6 responses return in issue order with correct tags.
- Lock: r1 issues 3 ops with req_lock=1,1,0 while r0 is valid -> r0 ready stays 0 until r1's third handshake, then r0 is granted next cycle.
- Backpressure: resp_ready=00 for 4 cycles with continuous r0 requests -> s1 and s2 fill, req_ready drops after 2 accepts, resp_d is held stable, and no result is lost after release.
- flush with both stages full and reset asserted mid-stream -> resp_valid=00 and busy=0 the next cycle (flush) or immediately (reset); the first op after recovery returns correct data at +2 cycles.
